// File: rtl/uart_command_receiver.sv
// rtl/uart_command_receiver.sv - 8N1 UART deserialiser plus two-byte ASCII drive-command parser
// Optional feature macro: UART_CMD_TIMEOUT_EN (letter-to-digit gap timeout in WAIT_MULT)

module uart_command_receiver #(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int BAUD           = 115_200,
    parameter int TIMEOUT_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_in,
    output logic [2:0] drive_command,
    output logic [2:0] multiplier,
    output logic       cmd_valid,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       frame_error,
    output logic       cmd_error,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);

    // Reject configurations where the half-bit sample point collapses or the timeout is empty
    if (CLKS_PER_BIT < 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_command_receiver: CLKS_PER_BIT must be >= 4 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic {
        P_WAIT_CMD,
        P_WAIT_MULT
    } p_state_t;

    logic       sync1, sync2, line_d, armed;
    logic [1:0] settle;
    logic       fall_edge;

    rx_state_t     rx_state, rx_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    shreg, sh_next;
    logic          byte_load, fe_set;

    p_state_t   p_state, p_next;
    logic [2:0] pending, pend_next;
    logic       cmd_load, err_set;
    logic       letter_ok, digit_ok;
    logic [2:0] letter_code, digit_val;

    // Synchroniser and edge detector; edges are ignored until the synced line has been seen high
    // after reset, so a line held low across reset cannot fake a start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            line_d <= 1'b1;
            armed  <= 1'b0;
            settle <= 2'd0;
        end else begin
            sync1  <= uart_in;
            sync2  <= sync1;
            line_d <= sync2;
            if (settle != 2'd2) begin
                settle <= settle + 2'd1;
            end
            if (settle == 2'd2 && sync2) begin
                armed <= 1'b1;
            end
        end
    end

    assign fall_edge = armed & line_d & ~sync2;
    assign busy      = (rx_state != RX_IDLE);

    // Deserialiser state, bit timing counter, shift register and byte/error strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state      <= RX_IDLE;
            cnt           <= '0;
            bit_idx       <= 3'd0;
            shreg         <= 8'h00;
            rx_byte       <= 8'h00;
            rx_byte_valid <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            rx_state      <= rx_next;
            cnt           <= cnt_next;
            bit_idx       <= bit_next;
            shreg         <= sh_next;
            rx_byte_valid <= byte_load;
            frame_error   <= fe_set;
            if (byte_load) begin
                rx_byte <= shreg;
            end
        end
    end

    // Deserialiser next state: sample mid-bit; IDLE is re-entered at mid-stop-bit for back-to-back frames
    always_comb begin
        rx_next   = rx_state;
        cnt_next  = cnt + CW'(1);
        bit_next  = bit_idx;
        sh_next   = shreg;
        byte_load = 1'b0;
        fe_set    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                cnt_next = '0;
                if (fall_edge) begin
                    rx_next = RX_START;
                end
            end
            RX_START: begin
                if (cnt == CW'(HALF_BIT - 1)) begin
                    cnt_next = '0;
                    bit_next = 3'd0;
                    rx_next  = sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_next = '0;
                    sh_next  = {sync2, shreg[7:1]};
                    bit_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        rx_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_next = '0;
                    if (sync2) begin
                        byte_load = 1'b1;
                        rx_next   = RX_IDLE;
                    end else begin
                        fe_set  = 1'b1;
                        rx_next = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                cnt_next = '0;
                if (sync2) begin
                    rx_next = RX_IDLE;
                end
            end
            default: begin
                rx_next  = RX_IDLE;
                cnt_next = '0;
            end
        endcase
    end

    // Decode the received byte as a direction letter or a multiplier digit
    always_comb begin
        letter_ok   = 1'b1;
        letter_code = 3'd0;
        case (rx_byte)
            8'h53:   letter_code = 3'd0;
            8'h46:   letter_code = 3'd1;
            8'h42:   letter_code = 3'd2;
            8'h4C:   letter_code = 3'd3;
            8'h52:   letter_code = 3'd4;
            default: letter_ok   = 1'b0;
        endcase
    end

    assign digit_ok  = (rx_byte[7:3] == 5'b00110);
    assign digit_val = rx_byte[2:0];

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    // Gap counter: zero on entry to WAIT_MULT and whenever a replacement letter arrives
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (p_state != P_WAIT_MULT || (rx_byte_valid && letter_ok)) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign tmo_hit = (p_state == P_WAIT_MULT) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

    // Parser state, pending letter and registered command outputs/strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            p_state       <= P_WAIT_CMD;
            pending       <= 3'd0;
            drive_command <= 3'd0;
            multiplier    <= 3'd0;
            cmd_valid     <= 1'b0;
            cmd_error     <= 1'b0;
        end else begin
            p_state   <= p_next;
            pending   <= pend_next;
            cmd_valid <= cmd_load;
            cmd_error <= err_set;
            if (cmd_load) begin
                drive_command <= pending;
                multiplier    <= digit_val;
            end
        end
    end

    // Parser next state: a framing error silently abandons any pending letter; a byte beats a timeout
    always_comb begin
        p_next    = p_state;
        pend_next = pending;
        cmd_load  = 1'b0;
        err_set   = 1'b0;
        if (frame_error) begin
            p_next = P_WAIT_CMD;
        end else if (rx_byte_valid) begin
            case (p_state)
                P_WAIT_CMD: begin
                    if (letter_ok) begin
                        pend_next = letter_code;
                        p_next    = P_WAIT_MULT;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                P_WAIT_MULT: begin
                    if (digit_ok) begin
                        cmd_load = 1'b1;
                        p_next   = P_WAIT_CMD;
                    end else if (letter_ok) begin
                        err_set   = 1'b1;
                        pend_next = letter_code;
                    end else begin
                        err_set = 1'b1;
                        p_next  = P_WAIT_CMD;
                    end
                end
                default: p_next = P_WAIT_CMD;
            endcase
        end
`ifdef UART_CMD_TIMEOUT_EN
        else if (tmo_hit) begin
            err_set = 1'b1;
            p_next  = P_WAIT_CMD;
        end
`endif
    end

endmodule
